// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-master DataMem arbiter.
// State encoding is fixed so waveforms and debug scripts can decode it numerically.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_RD     = 3'd1,
        ARB_WR     = 3'd2,
        ARB_WR_CHK = 3'd3,
        ARB_RESP   = 3'd4
    } arb_state_t;

    // Pattern DataMem drives on rdata when it does not acknowledge a read.
    localparam logic [31:0] DMEM_POISON = 32'hcccc_cccc;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both master request/response channels, the DataMem port and the grant index.
// The slave modport is the arbiter's view; master is the view of the masters plus DataMem.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic [31:0]       m0_rdata;
    logic              m0_done;
    logic              m0_err;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic [31:0]       m1_rdata;
    logic              m1_done;
    logic              m1_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_read_acc;
    logic              mem_write_acc;

    logic              grant;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_rdata, m0_done, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_rdata, m1_done, m1_err,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_read_acc, mem_write_acc,
        output grant
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_rdata, m0_done, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_rdata, m1_done, m1_err,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_read_acc, mem_write_acc,
        input  grant
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way winner select; ptr names the master favoured on a tie.
// With rr_en low master 0 wins whenever it requests.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       rr_en,
    output logic       any,
    output logic       win
);

    always_comb begin
        any = |req;
        win = 1'b0;
        if (!rr_en) begin
            win = ~req[0];
        end else if (&req) begin
            win = ptr;
        end else begin
            win = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one DataMem port between two masters; done pulses 2 cycles (read) / 3 cycles (write) after grant.
// Masters hold req until their done; a losing master just waits, one idle bubble between transactions.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              pick_any;
    logic              pick_win;
    logic              rr_ptr;
    logic              grant_q;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       lat_wdata;
    logic [31:0]       m0_rdata_q;
    logic [31:0]       m1_rdata_q;
    logic              m0_err_q;
    logic              m1_err_q;
    logic              rsp_cap;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    rr_pick2 u_pick (
        .req   ({bus.m1_req, bus.m0_req}),
        .ptr   (rr_ptr),
        .rr_en (RR_EN),
        .any   (pick_any),
        .win   (pick_win)
    );

    assign req_we    = pick_win ? bus.m1_we    : bus.m0_we;
    assign req_addr  = pick_win ? bus.m1_addr  : bus.m0_addr;
    assign req_wdata = pick_win ? bus.m1_wdata : bus.m0_wdata;

    // write_acc is registered inside DataMem, so it is judged one cycle after the strobe
    assign rsp_cap   = (state == ARB_RD) || (state == ARB_WR_CHK);
    assign rsp_rdata = (state == ARB_RD) ? bus.mem_rdata : 32'h0;
    assign rsp_err   = (state == ARB_RD) ? ~bus.mem_read_acc : ~bus.mem_write_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:   if (pick_any) next_state = req_we ? ARB_WR : ARB_RD;
            ARB_RD:     next_state = ARB_RESP;
            ARB_WR:     next_state = ARB_WR_CHK;
            ARB_WR_CHK: next_state = ARB_RESP;
            ARB_RESP:   next_state = ARB_IDLE;
            default:    next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.m0_done   = 1'b0;
        bus.m1_done   = 1'b0;
        case (state)
            ARB_RD:   bus.mem_read  = 1'b1;
            ARB_WR:   bus.mem_write = 1'b1;
            ARB_RESP: begin
                bus.m0_done = ~grant_q;
                bus.m1_done = grant_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            grant_q    <= 1'b0;
            rr_ptr     <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            // request fields are frozen here; later changes on the master side are ignored
            if (state == ARB_IDLE && pick_any) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                grant_q   <= pick_win;
                rr_ptr    <= ~pick_win;
            end
            if (rsp_cap) begin
                if (grant_q) begin
                    m1_rdata_q <= rsp_rdata;
                    m1_err_q   <= rsp_err;
                end else begin
                    m0_rdata_q <= rsp_rdata;
                    m0_err_q   <= rsp_err;
                end
            end
        end
    end

    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m0_err    = m0_err_q;
    assign bus.m1_err    = m1_err_q;
    assign bus.grant     = grant_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter that shares the single DataMem port (RAM plus peripheral window) between requester 0 (CPU load/store unit) and requester 1 (UART boot loader / DMA engine).
- Registers each granted transaction, sequences DataMem's read/write strobes and samples its read_acc/write_acc.
- Returns a one-cycle done pulse with read data and an error flag to the granted master.
- Sits between both masters and DataMem; DataMem itself is unchanged.

Parameters:
- RR_EN, 1: 1 = round-robin between masters; 0 = fixed priority, master 0 always wins.
- ADDR_W, 32: address width passed to DataMem.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request; held high until m0_done
- m0_we  in  1  master 0: 1 = write, 0 = read
- m0_addr  in  ADDR_W  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data, valid while m0_done = 1
- m0_done  out  1  master 0 one-cycle completion pulse
- m0_err  out  1  master 0 access not acknowledged; valid with m0_done
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done, m1_err: same as master 0, for master 1
- mem_read  out  1  to DataMem read
- mem_write  out  1  to DataMem write
- mem_addr  out  ADDR_W  to DataMem addr
- mem_wdata  out  32  to DataMem wdata
- mem_rdata  in  32  from DataMem rdata (combinational)
- mem_read_acc  in  1  from DataMem read_acc (combinational)
- mem_write_acc  in  1  from DataMem write_acc (registered, valid the cycle after the write strobe)
- grant  out  1  index of the master that owns the current or last transaction

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; all outputs 0; mem_addr/mem_wdata = 0.
  - Round-robin pointer favours master 0.
  - A transaction in flight is dropped silently; no done pulse is issued for it.
- FSM states: IDLE, RD, WR, WR_CHK, RESP.
- IDLE:
  - If any req is high at the clock edge, pick a winner.
  - Winner latches we, addr and wdata into internal registers; grant = winner index.
  - Next state is RD if we = 0, WR if we = 1. With no request, stay in IDLE.
- Arbitration, RR_EN = 1:
  - Only one requester: it wins.
  - Both requesting: the master not granted last wins.
  - Pointer updates only when a grant is issued.
- Arbitration, RR_EN = 0: m0 wins whenever m0_req = 1.
- RD:
  - mem_read = 1 and mem_addr = latched address for exactly one cycle.
  - At the edge: capture mem_rdata into the winner's rdata register; err = ~mem_read_acc; go to RESP.
- WR:
  - mem_write = 1 with latched addr/wdata for exactly one cycle; go to WR_CHK.
- WR_CHK:
  - mem_write = 0.
  - At the edge: err = ~mem_write_acc; rdata register = 0; go to RESP.
- RESP:
  - Winner's done = 1 for one cycle with rdata/err valid; loser's done stays 0.
  - Always go to IDLE; one bubble cycle separates transactions.
- mem_read and mem_write are never high together and are 0 in IDLE, WR_CHK and RESP.
- Latency, counted from the edge where req is sampled in IDLE:
  - Read: done visible 2 cycles later.
  - Write: done visible 3 cycles later.
  - Back-to-back same-master throughput: read 1 per 3 cycles, write 1 per 4 cycles.
- Boundary conditions:
  - Misaligned or unmapped address: DataMem does not acknowledge, so err = 1 and rdata = 0xcccccccc for reads; the arbiter does not check the address itself.
  - req dropped mid-transaction: the transaction completes anyway, because request fields are latched at grant; changes to a master's inputs after grant are ignored.
  - A new req from the granted master during RESP is not seen until IDLE.
  - Both masters requesting continuously (RR_EN = 1): grants alternate 0,1,0,1; neither master starves.
  - rdata/err registers hold their values after done falls; masters must sample only on done.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding constants: ARB_IDLE = 3'd0, ARB_RD = 3'd1, ARB_WR = 3'd2, ARB_WR_CHK = 3'd3, ARB_RESP = 3'd4.
  - DMEM_POISON = 32'hcccccccc, for bench checks.
- Optional sub-module rr_pick2: combinational two-way winner select from req[1:0], pointer and RR_EN.
- The FSM and datapath stay in dmem_arbiter.

Test Plan:
- m0 read addr 0x0000_0010 with RAM word 4 = 0x1234_5678 -> mem_read high for exactly 1 cycle; m0_done 2 cycles after sampling; m0_rdata = 0x12345678; m0_err = 0.
- m1 write 0xDEAD_BEEF to 0x0000_0020, then m1 read of the same address -> write done at +3 with err = 0; read returns 0xDEADBEEF.
- m0 and m1 both requesting reads every cycle for 8 transactions, RR_EN = 1 -> grant sequence 0,1,0,1,...; with RR_EN = 0 -> only m0 is served while m0_req stays high.
- m0 read of misaligned 0x0000_0002 and m0 write to 0x2000_0000 -> read: m0_err = 1, m0_rdata = 0xcccccccc; write: m0_err = 1 at done; RAM unchanged.
- Assert reset while in WR_CHK -> all outputs 0 immediately; no done pulse; the next m1 request is served normally, starting from IDLE.
- m0 drops m0_req in the cycle after grant during a read -> m0_done is still pulsed with the correct data; no second transaction is started.
